// File: rtl/muldiv_requester_pkg.sv
// muldiv_requester_pkg
//   Shared encodings for the multiply/divide path. Used by the requester,
//   the multiply/divide unit and the decode stage so all three agree on
//   the unit op codes, the E-stage request kinds and the requester FSM.
package muldiv_requester_pkg;

    // Op code carried on the unit's in_op port.
    typedef enum logic [1:0] {
        MD_OP_IDLE = 2'd0,
        MD_OP_MUL  = 2'd1,
        MD_OP_DIV  = 2'd2
    } md_op_e;

    // Kind of HI/LO-writing request coming from the E stage.
    typedef enum logic [1:0] {
        KIND_MUL  = 2'd0,
        KIND_DIV  = 2'd1,
        KIND_MTHI = 2'd2,
        KIND_MTLO = 2'd3
    } req_kind_e;

    // Requester FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_requester.sv
// muldiv_requester
//   Pipeline-side initiator for the multiply/divide unit. Accepts
//   MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage, owns the architectural
//   HI/LO registers, runs the unit's in/out valid/ready handshakes and
//   stalls the pipeline while an operation is outstanding.
//
//   Ports:
//     clk, reset            clock, asynchronous active-high reset
//     req_valid/req_kill    E-stage request and its flush
//     req_kind/req_sign     0=MUL 1=DIV 2=MTHI 3=MTLO, signed flag
//     req_a/req_b           rs / rt operands
//     use_hilo              E-stage instruction reads HI/LO
//     stall, busy           pipeline freeze, FSM not idle
//     hi, lo                architectural HI/LO
//     md_in_*               request channel to the unit
//     md_out_*              result channel from the unit
//
//   Build option: MD_DIV0_BYPASS_EN -- when defined, a DIV with a zero
//   divisor is dropped at acceptance (HI/LO unchanged, no stall).
module muldiv_requester
    import muldiv_requester_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_kill,
    input  logic [1:0]       req_kind,
    input  logic             req_sign,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             use_hilo,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] md_in_src0,
    output logic [WIDTH-1:0] md_in_src1,
    output logic [1:0]       md_in_op,
    output logic             md_in_sign,
    output logic             md_in_valid,
    input  logic             md_in_ready,
    input  logic             md_out_valid,
    output logic             md_out_ready,
    input  logic [WIDTH-1:0] md_out_res0,
    input  logic [WIDTH-1:0] md_out_res1
);

    md_state_e        state_q, state_d;
    md_op_e           op_q, op_d;
    logic [WIDTH-1:0] src0_q, src0_d;
    logic [WIDTH-1:0] src1_q, src1_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_issue;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        src0_d    = src0_q;
        src1_d    = src1_q;
        sign_d    = sign_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
`ifdef MD_DIV0_BYPASS_EN
        div_issue = (req_b != '0);
`else
        div_issue = 1'b1;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid && !req_kill) begin
                    case (req_kind_e'(req_kind))
                        KIND_MUL: begin
                            src0_d  = req_a;
                            src1_d  = req_b;
                            sign_d  = req_sign;
                            op_d    = MD_OP_MUL;
                            state_d = ST_ISSUE;
                        end
                        KIND_DIV: begin
                            // A bypassed divide completes here as a no-op.
                            if (div_issue) begin
                                src0_d  = req_a;
                                src1_d  = req_b;
                                sign_d  = req_sign;
                                op_d    = MD_OP_DIV;
                                state_d = ST_ISSUE;
                            end
                        end
                        KIND_MTHI: hi_d = req_a;
                        KIND_MTLO: lo_d = req_a;
                        default:   ;
                    endcase
                end
            end
            ST_ISSUE: begin
                if (md_in_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (md_out_valid) begin
                    hi_d    = md_out_res1;
                    lo_d    = md_out_res0;
                    op_d    = MD_OP_IDLE;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= MD_OP_IDLE;
            src0_q  <= '0;
            src1_q  <= '0;
            sign_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src0_q  <= src0_d;
            src1_q  <= src1_d;
            sign_q  <= sign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Handshake strobes decode straight from the state register, so the
    // unit never sees a combinational path from the E-stage inputs.
    assign md_in_valid  = (state_q == ST_ISSUE);
    assign md_out_ready = (state_q == ST_WAIT);
    assign md_in_src0   = src0_q;
    assign md_in_src1   = src1_q;
    assign md_in_sign   = sign_q;
    assign md_in_op     = op_q;
    assign hi           = hi_q;
    assign lo           = lo_q;
    assign busy         = (state_q != ST_IDLE);
    // Kill does not mask stall: the flushed instruction still has to wait.
    assign stall        = busy && (use_hilo || req_valid);

`ifndef SYNTHESIS
    // A result offered outside WAIT is a unit protocol error; it is ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(md_out_valid && state_q != ST_WAIT))
                else $error("muldiv_requester: md_out_valid outside WAIT");
        end
    end
`endif

endmodule

// File: tb/tb_muldiv_requester.sv
module tb_muldiv_requester;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_kill, req_sign, use_hilo;
    logic [1:0]  req_kind;
    logic [31:0] req_a, req_b;
    logic        stall, busy;
    logic [31:0] hi, lo;
    logic [31:0] md_in_src0, md_in_src1;
    logic [1:0]  md_in_op;
    logic        md_in_sign, md_in_valid, md_in_ready;
    logic        md_out_valid, md_out_ready;
    logic [31:0] md_out_res0, md_out_res1;

    int total = 0;
    int bad   = 0;

    // reference HI/LO state
    logic [31:0] m_hi, m_lo;

    // behavioural unit controls
    logic        unit_ready;
    int          unit_lat;
    logic        u_pend;
    int          u_cnt;
    logic [63:0] u_res;

    always #5 clk = ~clk;

    muldiv_requester #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_kill(req_kill), .req_kind(req_kind),
        .req_sign(req_sign), .req_a(req_a), .req_b(req_b), .use_hilo(use_hilo),
        .stall(stall), .busy(busy), .hi(hi), .lo(lo),
        .md_in_src0(md_in_src0), .md_in_src1(md_in_src1), .md_in_op(md_in_op),
        .md_in_sign(md_in_sign), .md_in_valid(md_in_valid), .md_in_ready(md_in_ready),
        .md_out_valid(md_out_valid), .md_out_ready(md_out_ready),
        .md_out_res0(md_out_res0), .md_out_res1(md_out_res1)
    );

    // Architectural result {HI, LO}; op 1=MUL, 2=DIV.
    function automatic logic [63:0] ref_res(input logic [1:0] op, input logic sgn,
                                            input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] ua, ub;
        int          q, r;
        if (op == 2'd1) begin
            if (sgn) begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            ua = {32'b0, a};
            ub = {32'b0, b};
            return ua * ub;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
        end
        return {a % b, a / b};
    endfunction

    // Unit model: accepts one request, waits unit_lat cycles, offers result.
    assign md_in_ready  = unit_ready;
    assign md_out_valid = u_pend && (u_cnt == 0);
    assign md_out_res0  = u_res[31:0];
    assign md_out_res1  = u_res[63:32];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            u_pend <= 1'b0;
            u_cnt  <= 0;
            u_res  <= '0;
        end else if (!u_pend) begin
            if (md_in_valid && md_in_ready) begin
                u_pend <= 1'b1;
                u_cnt  <= unit_lat;
                u_res  <= ref_res(md_in_op, md_in_sign, md_in_src0, md_in_src1);
            end
        end else if (u_cnt > 0) begin
            u_cnt <= u_cnt - 1;
        end else if (md_out_ready) begin
            u_pend <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
    endtask

    // One request: presented for a single cycle in IDLE, then followed to
    // retirement against the expected ISSUE/WAIT timeline.
    task automatic run_op(input logic [1:0] kind, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int rdly, input int lat);
        logic [63:0] exp;
        bit          issue;
        @(negedge clk);
        req_kind   = kind;
        req_sign   = sgn;
        req_a      = a;
        req_b      = b;
        req_valid  = 1'b1;
        req_kill   = 1'b0;
        use_hilo   = 1'b1;
        unit_ready = 1'b0;
        unit_lat   = lat;
        issue      = (kind <= 2'd1);
`ifdef MD_DIV0_BYPASS_EN
        if (kind == 2'd1 && b == 32'd0) issue = 1'b0;
`endif
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!issue) begin
            if (kind == 2'd2) m_hi = a;
            if (kind == 2'd3) m_lo = a;
            chk("noissue_busy", busy, 1'b0);
            chk("noissue_stall", stall, 1'b0);
            chk("noissue_in_valid", md_in_valid, 1'b0);
            chk("noissue_hi", hi, m_hi);
            chk("noissue_lo", lo, m_lo);
            return;
        end
        exp = ref_res((kind == 2'd0) ? 2'd1 : 2'd2, sgn, a, b);
        for (int i = 0; i <= rdly; i++) begin
            chk("issue_in_valid", md_in_valid, 1'b1);
            chk("issue_src0", md_in_src0, a);
            chk("issue_src1", md_in_src1, b);
            chk("issue_sign", md_in_sign, sgn);
            chk("issue_op", md_in_op, (kind == 2'd0) ? 2'd1 : 2'd2);
            chk("issue_stall", stall, 1'b1);
            unit_ready = (i == rdly);
            @(posedge clk); #1;
        end
        unit_ready = 1'b0;
        for (int i = 0; i <= lat; i++) begin
            chk("wait_out_ready", md_out_ready, 1'b1);
            chk("wait_in_valid", md_in_valid, 1'b0);
            chk("wait_stall", stall, 1'b1);
            chk("wait_op", md_in_op, (kind == 2'd0) ? 2'd1 : 2'd2);
            @(posedge clk); #1;
        end
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        chk("retire_busy", busy, 1'b0);
        chk("retire_stall", stall, 1'b0);
        chk("retire_op", md_in_op, 2'd0);
        chk("retire_hi", hi, m_hi);
        chk("retire_lo", lo, m_lo);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_kill = 1'b0; req_kind = 2'd0;
        req_sign = 1'b0; req_a = '0; req_b = '0; use_hilo = 1'b0;
        unit_ready = 1'b0; unit_lat = 0;
        m_hi = '0; m_lo = '0;
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_in_valid", md_in_valid, 1'b0);
        chk("rst_out_ready", md_out_ready, 1'b0);
        chk("rst_in_op", md_in_op, 2'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;

        // MULT -5 x 3, unit ready immediately
        run_op(2'd0, 1'b1, 32'hFFFF_FFFB, 32'd3, 0, 0);
        chk("mult_hi_const", hi, 32'hFFFF_FFFF);
        chk("mult_lo_const", lo, 32'hFFFF_FFF1);

        // DIVU 100 / 7 with MFLO waiting behind it
        run_op(2'd1, 1'b0, 32'd100, 32'd7, 0, 3);
        chk("divu_lo_const", lo, 32'd14);
        chk("divu_hi_const", hi, 32'd2);

        // MTHI then MFHI
        run_op(2'd2, 1'b0, 32'h1234, 32'd0, 0, 0);
        chk("mthi_const", hi, 32'h1234);

        // unit holds in_ready low for 5 cycles
        run_op(2'd0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0010, 5, 1);

        // killed MULT 2x2 is never accepted
        @(negedge clk);
        req_kind = 2'd0; req_sign = 1'b1; req_a = 32'd2; req_b = 32'd2;
        req_valid = 1'b1; req_kill = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_kill = 1'b0;
        chk("kill_busy", busy, 1'b0);
        chk("kill_in_valid", md_in_valid, 1'b0);
        chk("kill_hi", hi, m_hi);
        chk("kill_lo", lo, m_lo);

        // request held across the retire edge: MULT 3x4 then MTLO 0x55
        @(negedge clk);
        unit_lat = 0; unit_ready = 1'b1; use_hilo = 1'b0;
        req_kind = 2'd0; req_sign = 1'b0; req_a = 32'd3; req_b = 32'd4; req_valid = 1'b1;
        @(posedge clk); #1;
        req_kind = 2'd3; req_a = 32'h55;
        chk("chain_stall_issue", stall, 1'b1);
        @(posedge clk); #1;
        chk("chain_stall_wait", stall, 1'b1);
        @(posedge clk); #1;
        chk("chain_retire_stall", stall, 1'b0);
        chk("chain_retire_lo", lo, 32'd12);
        chk("chain_retire_hi", hi, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; unit_ready = 1'b0;
        m_hi = 32'd0; m_lo = 32'h55;
        chk("chain_mtlo_lo", lo, m_lo);
        chk("chain_mtlo_busy", busy, 1'b0);

        // async reset during WAIT of DIV 9/2
        @(negedge clk);
        unit_lat = 4; unit_ready = 1'b1;
        req_kind = 2'd1; req_sign = 1'b1; req_a = 32'd9; req_b = 32'd2; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        unit_ready = 1'b0;
        chk("rstwait_out_ready", md_out_ready, 1'b1);
        #2 reset = 1'b1;
        #1;
        m_hi = '0; m_lo = '0;
        chk("rstwait_hi", hi, m_hi);
        chk("rstwait_lo", lo, m_lo);
        chk("rstwait_busy", busy, 1'b0);
        chk("rstwait_op", md_in_op, 2'd0);
        @(negedge clk); reset = 1'b0;

        // divide by zero: bypassed or issued depending on the build
        run_op(2'd2, 1'b0, 32'hA5A5_0001, 32'd0, 0, 0);
        run_op(2'd1, 1'b0, 32'd8, 32'd0, 0, 2);

        // randomized mix
        for (int n = 0; n < 30; n++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            run_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, rb,
                   $urandom_range(0, 3), $urandom_range(0, 5));
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
